// File: rtl/seg_display_mux_pkg.sv
// Shared constants and types for the seven-segment display driver:
// digit index type, active-low segment codes, anode idle pattern and
// default divider values.
package disp_pkg;

    typedef logic [1:0] digit_idx_t;

    // Segment codes, active low, bit 7 = dp (off), bits 6:0 = gfedcba
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // All anodes high: no digit driven
    localparam logic [3:0] AN_OFF = 4'hF;

    // 1 kHz digit rate and 2 Hz blink half-period at 100 MHz
    localparam int DEF_SCAN_DIV  = 100000;
    localparam int DEF_BLINK_DIV = 25000000;

endpackage

// File: rtl/seg_display_mux_if.sv
// Signal bundle between the stopwatch counter stage and the display driver.
// No handshake: the driver samples minutes/seconds/adj/sel every cycle and
// never acknowledges them; an/seg are free-running registered outputs.
interface seg_display_mux_if;

    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [7:0] seg;

    modport master (
        output minutes, seconds, adj, sel,
        input  an, seg
    );

    modport slave (
        input  minutes, seconds, adj, sel,
        output an, seg
    );

endinterface

// File: rtl/seg_display_mux_seg7_decode.sv
// Combinational BCD digit to seven-segment (gfedcba, active low) decoder.
// Codes 10..15 never occur in normal use and decode to all segments off.
import disp_pkg::*;

module seg7_decode (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Lookup of segment pattern for one decimal digit
    always_comb begin
        seg_o = SEG_OFF[6:0];
        case (digit_i)
            4'd0: seg_o = SEG_0[6:0];
            4'd1: seg_o = SEG_1[6:0];
            4'd2: seg_o = SEG_2[6:0];
            4'd3: seg_o = SEG_3[6:0];
            4'd4: seg_o = SEG_4[6:0];
            4'd5: seg_o = SEG_5[6:0];
            4'd6: seg_o = SEG_6[6:0];
            4'd7: seg_o = SEG_7[6:0];
            4'd8: seg_o = SEG_8[6:0];
            4'd9: seg_o = SEG_9[6:0];
            default: seg_o = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit common-anode MM:SS display driver. A free-running scan counter
// steps the digit index every SCAN_DIV cycles; minutes/seconds are latched
// once per frame so a frame never mixes two different times.
// Optional field blinking is enabled by defining SEG_DISPLAY_BLINK_EN.
import disp_pkg::*;

module seg_display_mux #(
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_mux_if.slave   bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    digit_idx_t    d_q;
    logic [5:0]    snap_m_q;
    logic [5:0]    snap_s_q;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;
    logic          tick;
    logic [3:0]    digit;
    logic [6:0]    seg7;
    logic [3:0]    an_d;
    logic [7:0]    seg_d;
    logic          blank_m;
    logic          blank_s;

    assign tick = (cnt_q == CNT_MAX);

    // Scan counter, digit index and once-per-frame snapshot (taken on d 3->0)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            d_q      <= '0;
            snap_m_q <= '0;
            snap_s_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
            d_q   <= digit_idx_t'(d_q + 2'd1);
            if (d_q == 2'd3) begin
                snap_m_q <= bus.minutes;
                snap_s_q <= bus.seconds;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Select the decimal digit for the current position (values up to 63)
    always_comb begin
        digit = '0;
        case (d_q)
            2'd0: digit = 4'(snap_s_q % 6'd10);
            2'd1: digit = 4'(snap_s_q / 6'd10);
            2'd2: digit = 4'(snap_m_q % 6'd10);
            2'd3: digit = 4'(snap_m_q / 6'd10);
            default: digit = '0;
        endcase
    end

    seg7_decode u_decode (
        .digit_i (digit),
        .seg_o   (seg7)
    );

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;

    // Blink phase generator; held at the visible phase while not adjusting
    always_ff @(posedge clk) begin
        if (rst || !bus.adj) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blank_m = bus.adj & phase_q & ~bus.sel;
    assign blank_s = bus.adj & phase_q &  bus.sel;
`else
    logic unused_blink;
    assign unused_blink = ^{bus.adj, bus.sel, 32'(BLINK_DIV)};
    assign blank_m = 1'b0;
    assign blank_s = 1'b0;
`endif

    // Next anode/segment pattern: one-hot-low anode, dp lit as separator at d=2
    always_comb begin
        an_d = ~(4'b0001 << d_q);
        if (blank_m) an_d[3:2] = 2'b11;
        if (blank_s) an_d[1:0] = 2'b11;
        seg_d = {(d_q != 2'd2), seg7};
    end

    // Output register, lags the digit index by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux with SCAN_DIV=4, BLINK_DIV=8.
// The driver pushes the expected {an,seg} for every clock edge it drives;
// a monitor pops and compares one entry per cycle, #1 after the edge.
module tb_seg_display_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_display_mux_if bus ();

    seg_display_mux #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    always #5 clk = ~clk;

    logic [11:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // driver-side model state
    int         k;
    int         disp_m, disp_s;
    int         cur_m, cur_s;
    logic       cur_adj, cur_sel;
    int         b_cnt;
    logic       b_phase;

    task automatic model_clear();
        k = 0; disp_m = 0; disp_s = 0; b_cnt = 0; b_phase = 1'b0;
    endtask

    // one normal cycle: drive inputs, push expected output of the next edge
    task automatic step();
        int d, dig;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        @(negedge clk);
        rst = 1'b0;
        bus.minutes = 6'(cur_m);
        bus.seconds = 6'(cur_s);
        bus.adj = cur_adj;
        bus.sel = cur_sel;
        d = (k / 4) % 4;
        case (d)
            0: dig = disp_s % 10;
            1: dig = disp_s / 10;
            2: dig = disp_m % 10;
            default: dig = disp_m / 10;
        endcase
        e_seg = seg_tbl[dig];
        if (d == 2) e_seg[7] = 1'b0;
        e_an = 4'hF;
        e_an[d] = 1'b0;
`ifdef SEG_DISPLAY_BLINK_EN
        if (cur_adj && b_phase) begin
            if (cur_sel) e_an[1:0] = 2'b11;
            else         e_an[3:2] = 2'b11;
        end
        if (!cur_adj) begin
            b_cnt = 0; b_phase = 1'b0;
        end else if (b_cnt == 7) begin
            b_cnt = 0; b_phase = ~b_phase;
        end else begin
            b_cnt++;
        end
`endif
        exp_q.push_back({e_an, e_seg});
        if (k % 16 == 15) begin
            disp_m = cur_m;
            disp_s = cur_s;
        end
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        while (k % 16 != pos) step();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            exp_q.push_back({4'hF, 8'hFF});
        end
        model_clear();
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.an, bus.seg} !== e) begin
                n_err++;
                $display("FAIL an_seg k=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                         k, bus.an, bus.seg, e[11:8], e[7:0]);
            end
        end
    end

    initial begin
        bus.minutes = '0; bus.seconds = '0; bus.adj = 1'b0; bus.sel = 1'b0;
        cur_m = 0; cur_s = 0; cur_adj = 1'b0; cur_sel = 1'b0;
        model_clear();

        // reset held 3 cycles, then first frame shows zero snapshot
        do_reset(3);
        cur_m = 12; cur_s = 34;
        run(48);

        // input change mid-frame (d=1) only shows next frame
        run_to(5);
        cur_s = 35;
        run_to(0);
        run(16);

        // out-of-range and two-digit values
        cur_m = 59; cur_s = 63;
        run(32);
        cur_m = 0; cur_s = 9;
        run(32);

        // reset while d=2
        cur_m = 47; cur_s = 21;
        run_to(9);
        do_reset(1);
        run(36);

        // adjust mode: minutes field, then seconds field, then off
        cur_m = 7; cur_s = 8;
        cur_adj = 1'b1; cur_sel = 1'b0;
        run(40);
        cur_sel = 1'b1;
        run(24);
        cur_adj = 1'b0;
        run(16);

        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

- Drives the 4-digit common-anode seven-segment display. It consumes the 6-bit `minutes` and `seconds` values produced by the stopwatch counter stage.
- Converts each value to two decimal digits and time-multiplexes the four digits with a free-running scan counter.
- Latches a consistent snapshot of both values once per display frame.
- Optionally blinks the field being adjusted.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit (≥2). At 100 MHz this gives a 1 kHz digit rate.
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period (≥2).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `minutes`  in  6  binary minutes, 0..63 accepted.
- `seconds`  in  6  binary seconds, 0..63 accepted.
- `adj`  in  1  adjust mode; blink enable (used only with BLINK_EN).
- `sel`  in  1  blink field: 0 = minutes, 1 = seconds (used only with BLINK_EN).
- `an`  out  4  digit anodes, active low. `an[3]`=min tens, `an[2]`=min ones, `an[1]`=sec tens, `an[0]`=sec ones.
- `seg`  out  8  segments, active low. `seg[7]`=dp, `seg[6:0]`=gfedcba.

## Operation
- **Scan counter `cnt`**
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` is asserted when `cnt`==SCAN_DIV-1.
- **Digit index `d` (2 bits)**
  - Advances 0→1→2→3→0 on each `tick`.
  - `d`=k selects `an[k]`.
- **Snapshot**
  - On the edge where `d` goes 3→0, `minutes`/`seconds` are captured into `snap_m`/`snap_s`.
  - Input changes at any other time are not displayed until the next frame.
- **Decimal conversion**
  - tens = v/10, ones = v%10, for v in 0..63.
  - 60..63 therefore display as "60".."63" (no saturation, no error).
- **Segment codes (seg[6:0] with dp off)**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, 8-bit).
- **Decimal point**
  - Lit (`seg[7]`=0) only while `d`=2 (minutes/seconds separator).
- **Output register**
  - `an`/`seg` are registered from the current `d` and snapshot every cycle.
  - Exactly one anode is low except when blanked.
- **Reset values**
  - `cnt`=0, `d`=0, `snap_m`=0, `snap_s`=0.
  - `an`=4'hF, `seg`=8'hFF.
  - Blink phase = 0, blink counter = 0.
- **Reset mid-frame**
  - Reset takes effect at the next edge regardless of `cnt`/`d`.
  - Scanning restarts at `d`=0 with a zero snapshot.

## Timing
- `an`/`seg` lag `d` by exactly 1 cycle.
- First cycle after `rst` deasserts: outputs update at the following edge to `an`=E, `seg`=C0.
- Each digit is driven for exactly SCAN_DIV consecutive cycles. A frame is 4×SCAN_DIV cycles.
- Snapshot data first appears on `an[0]` one cycle after the capture edge.
- No handshake: inputs are sampled, never acknowledged.

## Configuration
- **`SEG_DISPLAY_BLINK_EN` defined**
  - A blink counter toggles `phase` every BLINK_DIV cycles.
  - While `adj`=1 and `phase`=1, the anodes of the selected field are forced high: `sel`=0 → `an[3:2]`, `sel`=1 → `an[1:0]`.
  - `seg` is unchanged. Other digits scan normally.
  - `adj`/`sel` are sampled combinationally into the output register (1-cycle latency).
  - `adj`=0 drives `phase` to 0 and clears the blink counter, so blinking always starts visible.
- **Not defined**
  - `adj`/`sel` ports exist but are ignored. No blink counter is synthesized. Display never blanks.

## Structure
- **Shared package `disp_pkg`**
  - Digit-index typedef (2 bits).
  - Segment constants SEG_0..SEG_9 and SEG_OFF.
  - Anode constant AN_OFF.
  - Default SCAN_DIV/BLINK_DIV constants.
- **Sub-module `seg7_decode`**
  - Combinational 4-bit digit → 7-bit segment code.
  - Instantiated once, on the muxed digit.
- Decimal split is done inline; it is only needed for 6-bit inputs.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_DIV=8.
- **Reset:** `rst`=1 for 3 cycles → `an`=F, `seg`=FF. Release → next edge `an`=E, `seg`=C0, each held 4 cycles.
- **Frame contents:** `minutes`=12, `seconds`=34 held across frames → sequence (E,99), (D,B0), (B,24), (7,F9), 4 cycles each, repeating.
- **Snapshot consistency:** `seconds` changes 34→35 while `d`=1 → rest of frame unchanged. Next frame shows `an`=E, `seg`=92.
- **Out of range:** `seconds`=63 → `an[1]` shows 82, `an[0]` shows B0.
- **Reset mid-frame:** `rst` asserted while `d`=2 → next edge `an`=F, `seg`=FF. After release, scan restarts at `an`=E with 4-cycle dwell.
- **Blink:** with `SEG_DISPLAY_BLINK_EN`, `adj`=1, `sel`=0 → `an[3:2]` never low during 8-cycle phase-1 windows; scan normally in phase 0. Without the macro, no blanking ever occurs.
